// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and pulse decode.
// A run request starts scanning at (0,0); dropping it finishes the current frame, then the block idles.
module vga_timing_gen #(
    parameter int H_DISP    = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISP    = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_DISP + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [15:0]      frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             hs_q, hs_d, vs_q, vs_d, vb_q, vb_d;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic             at_end, scan;
    logic [CNT_W-1:0] h_adv, v_adv;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            vb_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vb_q    <= vb_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        valid_d = valid_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        vb_d    = vb_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        scan    = 1'b0;
        at_end  = (h_q == H_LAST) && (v_q == V_LAST);
        h_adv   = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
        v_adv   = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? '0 : v_q + CNT_W'(1));

        if (pix_en) begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                        h_d     = '0;
                        v_d     = '0;
                        scan    = 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (at_end) frame_d = frame_q + 16'd1;
                    // A stopping scan parks at the frame boundary unless en returns on that very pixel.
                    if (state_q == STOP && at_end && !en) begin
                        state_d = IDLE;
                        h_d     = '0;
                        v_d     = '0;
                        valid_d = 1'b0;
                        hs_d    = ~HSYNC_POL;
                        vs_d    = ~VSYNC_POL;
                        vb_d    = 1'b0;
                    end else begin
                        state_d = en ? RUN : STOP;
                        h_d     = h_adv;
                        v_d     = v_adv;
                        scan    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Decode from the next counters so every output lines up with the pixel it describes.
        if (scan) begin
            valid_d = (h_d < H_ACT) && (v_d < V_ACT);
            hs_d    = (h_d >= HS_BEG && h_d <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vs_d    = (v_d >= VS_BEG && v_d <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
            vb_d    = (v_d >= V_ACT);
            ls_d    = (h_d == '0);
            fs_d    = (h_d == '0) && (v_d == '0);
        end
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign valid       = valid_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign vblank      = vb_q;
    assign busy        = (state_q != IDLE);
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 15x8 raster; a second instance checks inverted sync polarity.
module tb_vga_timing_gen;

    localparam int HT = 15;
    localparam int VT = 8;
    localparam int CW = 4;
    localparam int FR = HT * VT;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_en = 1'b1;
    logic          en = 1'b0;
    logic          hsync, vsync, valid, line_start, frame_start, vblank, busy;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [15:0]   frame_cnt;
    logic          hsync1, vsync1, valid1, ls1, fs1, vb1, busy1;
    logic [CW-1:0] h1, v1;
    logic [15:0]   fc1;

    int npass = 0;
    int ntot  = 0;
    int k     = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)) u0 (
        .pclk(pclk), .reset(reset), .pix_en(pix_en), .en(en),
        .hsync(hsync), .vsync(vsync), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .line_start(line_start), .frame_start(frame_start), .vblank(vblank),
        .busy(busy), .frame_cnt(frame_cnt));

    vga_timing_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW)) u1 (
        .pclk(pclk), .reset(reset), .pix_en(pix_en), .en(en),
        .hsync(hsync1), .vsync(vsync1), .valid(valid1), .h_cnt(h1), .v_cnt(v1),
        .line_start(ls1), .frame_start(fs1), .vblank(vb1),
        .busy(busy1), .frame_cnt(fc1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_pix(input int p);
        int h, v;
        logic hwin, vwin;
        h    = p % HT;
        v    = p / HT;
        hwin = (h >= 10 && h <= 12);
        vwin = (v >= 5 && v <= 6);
        chk("h_cnt", 32'(h_cnt), 32'(h));
        chk("v_cnt", 32'(v_cnt), 32'(v));
        chk("valid", 32'(valid), 32'(h < 8 && v < 4));
        chk("hsync", 32'(hsync), 32'(!hwin));
        chk("vsync", 32'(vsync), 32'(!vwin));
        chk("vblank", 32'(vblank), 32'(v >= 4));
        chk("line_start", 32'(line_start), 32'(h == 0));
        chk("frame_start", 32'(frame_start), 32'(p == 0));
        chk("busy", 32'(busy), 32'd1);
        chk("hsync_pol1", 32'(hsync1), 32'(hwin));
        chk("vsync_pol1", 32'(vsync1), 32'(vwin));
    endtask

    // Advance n pixels at full rate, checking continuity and pulses.
    task automatic adv(input int n);
        repeat (n) begin
            tick();
            k = (k + 1) % FR;
            chk("adv_h", 32'(h_cnt), 32'(k % HT));
            chk("adv_v", 32'(v_cnt), 32'(k / HT));
            chk("adv_ls", 32'(line_start), 32'(k % HT == 0));
            chk("adv_fs", 32'(frame_start), 32'(k == 0));
            chk("adv_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] fc);
        chk({tag, "_h"}, 32'(h_cnt), 32'd0);
        chk({tag, "_v"}, 32'(v_cnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_ls"}, 32'(line_start), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_vb"}, 32'(vblank), 32'd0);
        chk({tag, "_hs"}, 32'(hsync), 32'd1);
        chk({tag, "_vs"}, 32'(vsync), 32'd1);
        chk({tag, "_hs1"}, 32'(hsync1), 32'd0);
        chk({tag, "_vs1"}, 32'(vsync1), 32'd0);
        chk({tag, "_fc"}, 32'(frame_cnt), 32'(fc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        pix_en = 1'b1;
        tick();
        reset = 1'b0;
        k     = 0;
    endtask

    task automatic start();
        en = 1'b1;
        tick();
        k = 0;
        check_pix(0);
    endtask

    initial begin
        if ((HT - 1) >= (1 << CW) || (VT - 1) >= (1 << CW)) begin
            $display("FAIL cfg: CNT_W=%0d cannot hold HT-1=%0d / VT-1=%0d", CW, HT - 1, VT - 1);
            $fatal(1, "counter width too small");
        end

        // Reset state, then idle with en low.
        tick();
        check_idle("rst", 16'd0);
        reset = 1'b0;
        tick();
        check_idle("idle", 16'd0);

        // Full-rate frame: every pixel decoded, then wrap with frame_cnt=1.
        start();
        for (int p = 1; p < FR; p++) begin
            tick();
            check_pix(p);
        end
        tick();
        chk("f1_fc", 32'(frame_cnt), 32'd1);
        chk("f1_fs", 32'(frame_start), 32'd1);
        chk("f1_h", 32'(h_cnt), 32'd0);
        chk("f1_v", 32'(v_cnt), 32'd0);

        // Half-rate pix_en: each pixel held two cycles, pulses one cycle.
        do_reset();
        en = 1'b1;
        for (int p = 0; p < FR; p++) begin
            pix_en = 1'b1;
            tick();
            chk("hr_h", 32'(h_cnt), 32'(p % HT));
            chk("hr_v", 32'(v_cnt), 32'(p / HT));
            chk("hr_ls", 32'(line_start), 32'(p % HT == 0));
            chk("hr_fs", 32'(frame_start), 32'(p == 0));
            pix_en = 1'b0;
            tick();
            chk("hr_hold_h", 32'(h_cnt), 32'(p % HT));
            chk("hr_ls_off", 32'(line_start), 32'd0);
            chk("hr_fs_off", 32'(frame_start), 32'd0);
        end
        pix_en = 1'b1;
        tick();
        chk("hr_fc", 32'(frame_cnt), 32'd1);
        chk("hr_wrap_fs", 32'(frame_start), 32'd1);

        // en dropped at v=2: finish the frame, then idle.
        do_reset();
        start();
        adv(30);
        en = 1'b0;
        adv(FR - 1 - 30);
        tick();
        check_idle("stop", 16'd1);
        tick();
        check_idle("stop2", 16'd1);

        // en dropped at v=2 and restored at v=6: no discontinuity.
        do_reset();
        start();
        adv(30);
        en = 1'b0;
        adv(60);
        en = 1'b1;
        adv(FR - 90);
        chk("resume_fc", 32'(frame_cnt), 32'd1);
        adv(5);

        // Stop and restart on the last pixel: en wins, wrap stays in RUN.
        en = 1'b0;
        adv(FR - 1 - k);
        en = 1'b1;
        adv(1);
        chk("enwin_fc", 32'(frame_cnt), 32'd2);

        // Async reset mid-frame at (5,3) after one completed frame.
        do_reset();
        start();
        adv(FR + 50);
        chk("mid_h", 32'(h_cnt), 32'd5);
        chk("mid_v", 32'(v_cnt), 32'd3);
        chk("mid_fc", 32'(frame_cnt), 32'd1);
        #3 reset = 1'b1;
        #1;
        check_idle("async", 16'd0);
        tick();
        reset = 1'b0;
        en = 1'b0;
        tick();
        check_idle("post", 16'd0);
        start();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning); every parameter SHALL be overridable at instantiation:
- H_DISP 640: active pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: hsync width
- H_BP 48: horizontal back porch
- V_DISP 480: active lines
- V_FP 10: vertical front porch
- V_SYNC 2: vsync width
- V_BP 33: vertical back porch
- HSYNC_POL 0: hsync active level
- VSYNC_POL 0: vsync active level
- CNT_W 10: counter width; must hold HT-1 and VT-1
REQ-002 Derived values SHALL be HT = H_DISP+H_FP+H_SYNC+H_BP and VT = V_DISP+V_FP+V_SYNC+V_BP. Every porch/sync parameter SHALL be >= 1.
REQ-003 Ports, one per line (name, direction, width, meaning):
- pclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate clock enable
- en  in  1  run request
- hsync  out  1
- vsync  out  1
- valid  out  1  active-video pixel
- h_cnt  out  CNT_W  raw pixel counter
- v_cnt  out  CNT_W  raw line counter
- line_start  out  1  pulse
- frame_start  out  1  pulse
- vblank  out  1
- busy  out  1
- frame_cnt  out  16  completed frames

Function
REQ-004 FSM states SHALL be IDLE, RUN and STOP; busy = (state != IDLE).
REQ-005 The block SHALL take no action on cycles with pix_en = 0: state, counters and outputs hold, and line_start and frame_start are 0.
REQ-006 In IDLE, h_cnt and v_cnt SHALL be 0, and valid, line_start, frame_start and vblank SHALL be 0, with both syncs at their inactive level.
REQ-007 IDLE with en=1 and pix_en=1 SHALL move to RUN. The next cycle presents pixel (0,0).
REQ-008 In RUN or STOP, each pix_en SHALL advance h_cnt. When h_cnt = HT-1, h_cnt wraps to 0 and v_cnt increments, wrapping to 0 after VT-1.
REQ-009 Outputs SHALL be registered and aligned to the same cycle as the h_cnt/v_cnt they describe.
REQ-010 Output decode (while RUN or STOP):
- valid = h_cnt < H_DISP and v_cnt < V_DISP
- hsync active for h_cnt in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1]
- vsync active for v_cnt in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1]
- vblank = v_cnt >= V_DISP
REQ-011 line_start SHALL be 1 for exactly the first pix_en cycle on which each h_cnt = 0 is presented. frame_start SHALL likewise be 1 for the first such cycle at h_cnt = 0 and v_cnt = 0, including the first pixel after IDLE.
REQ-012 en=0 in RUN SHALL move to STOP; scanning continues unchanged.
REQ-013 en=1 in STOP SHALL return to RUN with no counter discontinuity.
REQ-014 When STOP is at pixel (HT-1, VT-1) and pix_en=1, the block SHALL enter IDLE instead of wrapping.
REQ-015 If en=1 on that same cycle, the block SHALL wrap and stay in RUN (en wins).
REQ-016 frame_cnt SHALL increment on every pix_en at pixel (HT-1, VT-1) in RUN or STOP, and wrap from 0xFFFF to 0.
REQ-017 Counter arithmetic SHALL be modulo 2^CNT_W. A CNT_W too small for HT-1 or VT-1 is a configuration error that the bench must flag.

Reset
REQ-018 reset=1 SHALL asynchronously force IDLE, counters 0, frame_cnt 0, syncs inactive, and valid, line_start, frame_start, vblank and busy all 0.
REQ-019 A reset asserted mid-frame SHALL take effect immediately, with no frame completion.
REQ-020 After reset deasserts, the first start SHALL follow REQ-007.

Verification
Bench timing: H_DISP=8, H_FP=2, H_SYNC=3, H_BP=2 (HT=15); V_DISP=4, V_FP=1, V_SYNC=2, V_BP=1 (VT=8); pix_en=1 unless stated.
REQ-021 Reset, then en=1 -> next cycle h=0, v=0, valid=1, frame_start=1, line_start=1; hsync low for h=10..12 only; vsync low for v=5..6 only; after 120 cycles, frame_cnt=1.
REQ-022 pix_en toggling 1,0 with en=1 -> one pixel every 2 cycles; pulses last exactly one cycle; frame_cnt=1 after 240 cycles.
REQ-023 en dropped at v=2 -> scanning continues; busy=1 until pixel (14,7); then IDLE, h=v=0, busy=0, syncs high.
REQ-024 en dropped at v=2, reasserted at v=6 -> no discontinuity; frame_start recurs at the next (0,0); busy stays 1.
REQ-025 reset asserted at h=5, v=3, between clock edges -> all outputs reach reset values before the next pclk edge; frame_cnt=0.
REQ-026 HSYNC_POL=1 and VSYNC_POL=1 -> sync pulses are high in the same windows; idle and reset level is low.
